// File: rtl/trashbin_pkg.sv
// rtl/trashbin_pkg.sv - shared encodings for the Trashbin core data path
package trashbin_pkg;

   // Access width encodings as driven on AccessWidth by the core
   typedef enum logic [1:0] {
      ACC_BYTE    = 2'b00,
      ACC_HALF    = 2'b01,
      ACC_WORD    = 2'b10,
      ACC_ILLEGAL = 2'b11
   } acc_width_e;

   // Memory bridge sequencing states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_DONE  = 2'b11
   } bridge_state_e;

   // Width of the RAM latency down-counter (latency 1..7)
   localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/load_aligner.sv
// rtl/load_aligner.sv - selects the addressed lane of a RAM word and extends it to 32 bits
module load_aligner
   import trashbin_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_offset,
   input  acc_width_e  i_width,
   input  logic        i_sign,
   output logic [31:0] o_data
);

   logic [31:0] w_shifted;

   assign w_shifted = i_word >> {i_offset, 3'b000};

   // Keep the low byte/half of the shifted word and sign- or zero-fill the rest
   always_comb begin
      o_data = w_shifted;
      case (i_width)
         ACC_BYTE: o_data = {{24{i_sign & w_shifted[7]}}, w_shifted[7:0]};
         ACC_HALF: o_data = {{16{i_sign & w_shifted[15]}}, w_shifted[15:0]};
         default:  o_data = w_shifted;
      endcase
   end

endmodule

// File: rtl/core_memory_bridge.sv
// rtl/core_memory_bridge.sv - core data port to word-organised on-die RAM bridge
module core_memory_bridge
   import trashbin_pkg::*;
#(
   parameter int RAM_ADDR_W  = 10,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  CoreClock,
   input  logic                  CoreResetN,
   input  logic [31:0]           AddressBus,
   input  logic                  ReadAssert,
   input  logic                  WriteAssert,
   input  logic [31:0]           DataWriteBus,
   input  logic [1:0]            AccessWidth,
   input  logic                  SignExtend,
   output logic [31:0]           DataReadBus,
   output logic                  ReadOK,
   output logic                  WriteOK,
   output logic                  AccessFault,
   output logic [RAM_ADDR_W-1:0] RamAddress,
   output logic                  RamReadEnable,
   output logic                  RamWriteEnable,
   output logic [3:0]            RamByteEnable,
   output logic [31:0]           RamWriteData,
   input  logic [31:0]           RamReadData
);

   // WAIT counts down from latency-1 so the capture edge lands one cycle after data is valid
   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RAM_LATENCY - 1);

   bridge_state_e          r_state;
   logic [RAM_ADDR_W+1:0]  r_addr;
   acc_width_e             r_width;
   logic                   r_sign;
   logic                   r_is_write;
   logic [LAT_CNT_W-1:0]   r_cnt;

   acc_width_e             w_width;
   logic                   w_req;
   logic                   w_fault;
   logic                   w_range_fault;
   logic                   w_align_fault;
   logic [3:0]             w_be;
   logic [31:0]            w_wdata;
   logic [31:0]            w_load;

   assign w_width       = acc_width_e'(AccessWidth);
   assign w_req         = ReadAssert | WriteAssert;
   assign w_range_fault = |AddressBus[31:RAM_ADDR_W+2];
   assign w_align_fault = ((w_width == ACC_HALF) && AddressBus[0]) ||
                          ((w_width == ACC_WORD) && (AddressBus[1:0] != 2'b00));
   assign w_fault       = (w_width == ACC_ILLEGAL) | w_align_fault | w_range_fault |
                          (ReadAssert & WriteAssert);

   // RAM word address always follows the latched request address
   assign RamAddress = r_addr[RAM_ADDR_W+1:2];

   // Replicate store data across lanes and build the lane mask from the byte offset
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = DataWriteBus;
      case (w_width)
         ACC_BYTE: begin
            w_be    = 4'b0001 << AddressBus[1:0];
            w_wdata = {4{DataWriteBus[7:0]}};
         end
         ACC_HALF: begin
            w_be    = 4'b0011 << AddressBus[1:0];
            w_wdata = {2{DataWriteBus[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = DataWriteBus;
         end
      endcase
   end

   load_aligner u_load_aligner (
      .i_word   (RamReadData),
      .i_offset (r_addr[1:0]),
      .i_width  (r_width),
      .i_sign   (r_sign),
      .o_data   (w_load)
   );

   // Request sequencer: accept, issue one RAM strobe, wait for read data, hold OK until request drops
   always_ff @(posedge CoreClock or negedge CoreResetN) begin
      if (!CoreResetN) begin
         r_state        <= ST_IDLE;
         r_addr         <= '0;
         r_width        <= ACC_BYTE;
         r_sign         <= 1'b0;
         r_is_write     <= 1'b0;
         r_cnt          <= '0;
         DataReadBus    <= '0;
         ReadOK         <= 1'b0;
         WriteOK        <= 1'b0;
         AccessFault    <= 1'b0;
         RamReadEnable  <= 1'b0;
         RamWriteEnable <= 1'b0;
         RamByteEnable  <= 4'b0000;
         RamWriteData   <= '0;
      end else begin
         // Strobes are single-cycle; only the accept branch below raises them
         RamReadEnable  <= 1'b0;
         RamWriteEnable <= 1'b0;
         RamByteEnable  <= 4'b0000;
         RamWriteData   <= '0;
         case (r_state)
            ST_IDLE: begin
               if (w_req) begin
                  r_addr     <= AddressBus[RAM_ADDR_W+1:0];
                  r_width    <= w_width;
                  r_sign     <= SignExtend;
                  r_is_write <= WriteAssert & ~ReadAssert;
                  if (w_fault) begin
                     r_state     <= ST_DONE;
                     AccessFault <= 1'b1;
                     DataReadBus <= '0;
                     ReadOK      <= ReadAssert;
                     WriteOK     <= ~ReadAssert;
                  end else begin
                     r_state <= ST_ISSUE;
                     if (WriteAssert) begin
                        RamWriteEnable <= 1'b1;
                        RamByteEnable  <= w_be;
                        RamWriteData   <= w_wdata;
                     end else begin
                        RamReadEnable <= 1'b1;
                     end
                  end
               end
            end
            ST_ISSUE: begin
               if (r_is_write) begin
                  r_state     <= ST_DONE;
                  WriteOK     <= 1'b1;
                  AccessFault <= 1'b0;
               end else begin
                  r_state <= ST_WAIT;
                  r_cnt   <= LAT_LOAD;
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_state     <= ST_DONE;
                  DataReadBus <= w_load;
                  ReadOK      <= 1'b1;
                  AccessFault <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_DONE: begin
               if (r_is_write ? !WriteAssert : !ReadAssert) begin
                  r_state     <= ST_IDLE;
                  ReadOK      <= 1'b0;
                  WriteOK     <= 1'b0;
                  AccessFault <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_core_memory_bridge.sv
// tb/tb_core_memory_bridge.sv - scoreboard bench for core_memory_bridge
module tb_core_memory_bridge;

   logic        clk;
   logic        rst_n;
   logic [31:0] addr_bus;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] wdata_bus;
   logic [1:0]  acc_w;
   logic        sext;
   logic [31:0] rdata_bus;
   logic        read_ok;
   logic        write_ok;
   logic        fault;
   logic [9:0]  ram_addr;
   logic        ram_re;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] ram_wd;
   logic [31:0] ram_rd;

   core_memory_bridge #(.RAM_ADDR_W(10), .RAM_LATENCY(1)) dut (
      .CoreClock      (clk),
      .CoreResetN     (rst_n),
      .AddressBus     (addr_bus),
      .ReadAssert     (rd_req),
      .WriteAssert    (wr_req),
      .DataWriteBus   (wdata_bus),
      .AccessWidth    (acc_w),
      .SignExtend     (sext),
      .DataReadBus    (rdata_bus),
      .ReadOK         (read_ok),
      .WriteOK        (write_ok),
      .AccessFault    (fault),
      .RamAddress     (ram_addr),
      .RamReadEnable  (ram_re),
      .RamWriteEnable (ram_we),
      .RamByteEnable  (ram_be),
      .RamWriteData   (ram_wd),
      .RamReadData    (ram_rd)
   );

   typedef struct {
      bit          is_read;
      bit          flt;
      logic [31:0] data;
      int          lat;
      int          start;
   } resp_t;

   typedef struct {
      bit          is_wr;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } strobe_t;

   resp_t   resp_q[$];
   strobe_t strobe_q[$];
   int      checks = 0;
   int      errors = 0;
   int      cyc = 0;
   bit      prev_ok = 0;
   logic [31:0] mem [0:1023];

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM with one cycle read latency and byte-lane writes
   always @(posedge clk) begin
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_addr][b*8 +: 8] <= ram_wd[b*8 +: 8];
      if (ram_re) ram_rd <= mem[ram_addr];
   end

   // Monitor: RAM strobes and core-side completions against the scoreboard
   always @(negedge clk) begin
      strobe_t s;
      resp_t   e;
      bit      ok;
      if (ram_re || ram_we) begin
         checks++;
         if (strobe_q.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected re=%0b we=%0b addr=%0h", ram_re, ram_we, ram_addr);
         end else begin
            s = strobe_q.pop_front();
            if (ram_we !== s.is_wr || ram_re === ram_we || ram_addr !== s.addr ||
                (s.is_wr && (ram_be !== s.be || ram_wd !== s.wd))) begin
               errors++;
               $display("FAIL strobe got re=%0b we=%0b addr=%0h be=%b wd=%h exp we=%0b addr=%0h be=%b wd=%h",
                        ram_re, ram_we, ram_addr, ram_be, ram_wd, s.is_wr, s.addr, s.be, s.wd);
            end
         end
      end
      if (!ram_we) begin
         checks++;
         if (ram_be !== 4'b0000) begin
            errors++;
            $display("FAIL be_idle got %b exp 0000", ram_be);
         end
      end
      ok = read_ok | write_ok;
      if (ok && !prev_ok) begin
         checks++;
         if (resp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected rok=%0b wok=%0b", read_ok, write_ok);
         end else begin
            e = resp_q.pop_front();
            if (read_ok !== e.is_read || write_ok !== !e.is_read || fault !== e.flt ||
                (e.is_read && rdata_bus !== e.data) || (cyc - e.start) != e.lat) begin
               errors++;
               $display("FAIL resp got rok=%0b wok=%0b flt=%0b data=%h lat=%0d exp rd=%0b flt=%0b data=%h lat=%0d",
                        read_ok, write_ok, fault, rdata_bus, cyc - e.start, e.is_read, e.flt, e.data, e.lat);
            end
         end
      end
      prev_ok = ok;
   end

   task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {32'(rdata_bus ^ ram_wd), read_ok, write_ok, fault, ram_re, ram_we, ram_be,
              17'(ram_addr), 7'(|rdata_bus), 1'(|ram_wd)};
   endfunction

   task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] w,
                         input bit s, input logic [31:0] wd, input bit flt,
                         input logic [31:0] exp_d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      strobe_t st;
      resp_t   r;
      bit      seen;
      @(negedge clk);
      if (!flt) begin
         st.is_wr = wr; st.addr = a[11:2]; st.be = exp_be; st.wd = exp_wd;
         strobe_q.push_back(st);
      end
      r.is_read = rd; r.flt = flt; r.data = flt ? 32'h0 : exp_d;
      r.lat = flt ? 1 : (rd ? 3 : 2); r.start = cyc;
      resp_q.push_back(r);
      addr_bus = a; acc_w = w; sext = s; wdata_bus = wd; rd_req = rd; wr_req = wr;
      @(negedge clk);
      addr_bus = ~a; acc_w = ~w; sext = ~s; wdata_bus = ~wd;
      seen = read_ok | write_ok;
      for (int t = 0; t < 20 && !seen; t++) begin
         @(negedge clk);
         seen = read_ok | write_ok;
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL ok_timeout addr=%h", a);
      end
      @(negedge clk);
      check_val("ok_held", 64'(read_ok | write_ok), 64'(seen));
      rd_req = 0; wr_req = 0;
      @(negedge clk);
      check_val("ok_drop", 64'({read_ok, write_ok, fault}), 64'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h01010101;
      mem[1] = 32'h80112233;
      mem[2] = 32'hDEADBEEF;
      mem[1023] = 32'h13579BDF;
      ram_rd = 0;
      rst_n = 0; addr_bus = 0; rd_req = 0; wr_req = 0; wdata_bus = 0; acc_w = 0; sext = 0;
      repeat (2) @(negedge clk);
      check_val("reset_outputs", all_outs(), 64'h0);
      rst_n = 1;
      @(negedge clk);

      // loads before any store
      do_req(1, 0, 32'h8, 2'b10, 0, 0, 0, 32'hDEADBEEF, 0, 0);
      do_req(1, 0, 32'h7, 2'b00, 1, 0, 0, 32'hFFFFFF80, 0, 0);
      do_req(1, 0, 32'h7, 2'b00, 0, 0, 0, 32'h00000080, 0, 0);
      do_req(1, 0, 32'h4, 2'b01, 1, 0, 0, 32'h00002233, 0, 0);
      do_req(1, 0, 32'h6, 2'b01, 1, 0, 0, 32'hFFFF8011, 0, 0);
      do_req(1, 0, 32'h5, 2'b00, 1, 0, 0, 32'h00000022, 0, 0);
      // stores with lane replication
      do_req(0, 1, 32'h6, 2'b01, 0, 32'h1234ABCD, 0, 0, 4'b1100, 32'hABCDABCD);
      do_req(0, 1, 32'h9, 2'b00, 0, 32'h000000A5, 0, 0, 4'b0010, 32'hA5A5A5A5);
      do_req(0, 1, 32'hC, 2'b10, 0, 32'hCAFEF00D, 0, 0, 4'b1111, 32'hCAFEF00D);
      // read back merged words, including the top RAM word
      do_req(1, 0, 32'h4, 2'b10, 0, 0, 0, 32'hABCD2233, 0, 0);
      do_req(1, 0, 32'h8, 2'b10, 0, 0, 0, 32'hDEADA5EF, 0, 0);
      do_req(1, 0, 32'hC, 2'b10, 0, 0, 0, 32'hCAFEF00D, 0, 0);
      do_req(1, 0, 32'hFFC, 2'b10, 0, 0, 0, 32'h13579BDF, 0, 0);
      // faults never reach RAM
      do_req(1, 0, 32'h2, 2'b10, 0, 0, 1, 0, 0, 0);
      do_req(1, 0, 32'h1000, 2'b10, 0, 0, 1, 0, 0, 0);
      do_req(1, 1, 32'h8, 2'b10, 0, 32'h55, 1, 0, 0, 0);
      do_req(1, 0, 32'h8, 2'b11, 0, 0, 1, 0, 0, 0);
      do_req(0, 1, 32'h3, 2'b01, 0, 32'h77, 1, 0, 0, 0);

      // reset while waiting for read data aborts the load
      @(negedge clk);
      begin
         strobe_t st;
         st.is_wr = 0; st.addr = 10'd2; st.be = 0; st.wd = 0;
         strobe_q.push_back(st);
      end
      addr_bus = 32'h8; acc_w = 2'b10; sext = 0; rd_req = 1;
      repeat (2) @(negedge clk);
      #1 rst_n = 0;
      #1 check_val("reset_in_wait", all_outs(), 64'h0);
      rd_req = 0;
      @(negedge clk);
      rst_n = 1;

      // reset during the issue cycle drops the read strobe at once
      @(negedge clk);
      addr_bus = 32'h4; acc_w = 2'b10; rd_req = 1;
      @(posedge clk);
      #2 rst_n = 0;
      #1 check_val("reset_in_issue", all_outs(), 64'h0);
      @(negedge clk);
      rd_req = 0;
      @(negedge clk);
      rst_n = 1;

      do_req(1, 0, 32'h8, 2'b10, 0, 0, 0, 32'hDEADA5EF, 0, 0);
      do_req(0, 1, 32'h10, 2'b10, 0, 32'h0BADCAFE, 0, 0, 4'b1111, 32'h0BADCAFE);
      do_req(1, 0, 32'h12, 2'b01, 0, 0, 0, 32'h00000BAD, 0, 0);

      repeat (3) @(negedge clk);
      check_val("queues_drained", 64'({resp_q.size(), strobe_q.size()}), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
